pellet_map: RTL and testbench

//  Tile-based pellet store for the maze: per-tile pellet kind, pixel-level pellet

---
 rtl/pellet_map.sv | 202 ++++++++++++++++++++
 tb/tb_pellet_map.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_map.sv
// Tile pellet store: per-tile kind map refilled from a built-in maze layout, pixel flags, eating, score, power timer.
// Build option PELLET_BCD_SCORE_EN: score_out holds packed BCD digits and saturates at all nines.
module pellet_map #(
    parameter int TILE_LOG2   = 5,
    parameter int COLS        = 20,
    parameter int ROWS        = 11,
    parameter int DOT_PX      = 5,
    parameter int POWER_PX    = 11,
    parameter int PTS_DOT     = 1,
    parameter int PTS_POWER   = 5,
    parameter int POWER_TICKS = 480,
    parameter int SCORE_W     = 16
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            frame_tick,
    input  logic                            eat_valid,
    input  logic [9:0]                      eat_x,
    input  logic [9:0]                      eat_y,
    output logic                            eat_done,
    output logic [1:0]                      eat_kind,
    output logic                            is_dot,
    output logic                            is_power,
    output logic                            is_wall,
    output logic                            power_active,
    output logic [$clog2(COLS*ROWS+1)-1:0]  pellets_left,
    output logic [SCORE_W-1:0]              score_out,
    output logic [7:0]                      level_out,
    output logic                            busy
);
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);
    localparam int CW   = $clog2(N + 1);
    localparam int RW   = $clog2(ROWS);
    localparam int KW   = $clog2(COLS);
    localparam int TW   = $clog2(POWER_TICKS + 1);
    localparam int EDGE = 1 << TILE_LOG2;

    typedef enum logic {S_REFILL, S_RUN} state_t;

    state_t        state;
    logic [1:0]    map [N];
    logic [AW-1:0] sweep_idx;
    logic [RW-1:0] sweep_row;
    logic [KW-1:0] sweep_col;
    logic [TW-1:0] timer;

    // Maze layout: border walls, wall posts on even rows every 4th column,
    // power pellets in the four inner corners, empty spawn tile in the centre.
    function automatic logic [1:0] rom_kind(input int r, input int c);
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 2'd3;
        if ((r % 2 == 0) && (c % 4 == 0)) return 2'd3;
        if ((c == 2 || c == COLS - 3) && (r == 2 || r == ROWS - 3)) return 2'd2;
        if (c == COLS / 2 && r == ROWS / 2) return 2'd0;
        return 2'd1;
    endfunction

    // MSB set means the coordinate lies outside the grid.
    function automatic logic [AW:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
        logic [9:0]    tx;
        logic [9:0]    ty;
        logic [AW-1:0] a;
        tx = x >> TILE_LOG2;
        ty = y >> TILE_LOG2;
        a  = AW'(ty * COLS + tx);
        return {(tx >= 10'(COLS)) || (ty >= 10'(ROWS)), a};
    endfunction

    function automatic logic in_square(input int ox, input int oy, input int size);
        int lo;
        lo = (EDGE - size) / 2;
        return (ox >= lo) && (ox < lo + size) && (oy >= lo) && (oy < lo + size);
    endfunction

    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s, input int pts);
`ifdef PELLET_BCD_SCORE_EN
        logic [SCORE_W-1:0] r;
        int carry;
        int d;
        r     = '0;
        carry = pts;
        for (int k = 0; k < SCORE_W / 4; k++) begin
            d            = int'(s[4*k +: 4]) + carry;
            r[4*k +: 4]  = 4'(d % 10);
            carry        = d / 10;
        end
        if (carry != 0) r = {(SCORE_W / 4){4'h9}};
        return r;
`else
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W + 1)'(pts);
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`endif
    endfunction

    logic [AW:0] eat_loc;
    logic [AW:0] pix_loc;
    logic [1:0]  eat_tile;
    logic [1:0]  pix_tile;
    logic [1:0]  rom_tile;
    logic        eat_live;
    logic        rom_live;
    int          eat_pts;
    int          pix_ox;
    int          pix_oy;

    always_comb begin
        eat_loc  = tile_addr(eat_x, eat_y);
        pix_loc  = tile_addr(DrawX, DrawY);
        eat_tile = eat_loc[AW] ? 2'd0 : map[eat_loc[AW-1:0]];
        pix_tile = pix_loc[AW] ? 2'd0 : map[pix_loc[AW-1:0]];
        rom_tile = rom_kind(int'(sweep_row), int'(sweep_col));
        eat_live = (eat_tile == 2'd1) || (eat_tile == 2'd2);
        rom_live = (rom_tile == 2'd1) || (rom_tile == 2'd2);
        eat_pts  = (eat_tile == 2'd2) ? PTS_POWER : PTS_DOT;
        pix_ox   = int'(DrawX[TILE_LOG2-1:0]);
        pix_oy   = int'(DrawY[TILE_LOG2-1:0]);
    end

    assign power_active = (timer != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_REFILL;
            sweep_idx    <= '0;
            sweep_row    <= '0;
            sweep_col    <= '0;
            busy         <= 1'b0;
            pellets_left <= '0;
            score_out    <= '0;
            level_out    <= '0;
            timer        <= '0;
            eat_done     <= 1'b0;
            eat_kind     <= 2'd0;
            for (int i = 0; i < N; i++) map[i] <= 2'd0;
        end else begin
            eat_done <= eat_valid;
            eat_kind <= 2'd0;
            if (frame_tick && timer != '0) timer <= timer - TW'(1);

            case (state)
                S_REFILL: begin
                    map[sweep_idx] <= rom_tile;
                    if (rom_live) pellets_left <= pellets_left + CW'(1);
                    if (sweep_idx == AW'(N - 1)) begin
                        state     <= S_RUN;
                        busy      <= 1'b0;
                        sweep_idx <= '0;
                        sweep_row <= '0;
                        sweep_col <= '0;
                    end else begin
                        busy      <= 1'b1;
                        sweep_idx <= sweep_idx + AW'(1);
                        if (sweep_col == KW'(COLS - 1)) begin
                            sweep_col <= '0;
                            sweep_row <= sweep_row + RW'(1);
                        end else begin
                            sweep_col <= sweep_col + KW'(1);
                        end
                    end
                end
                default: begin
                    // Single-cycle read-modify-write, so back-to-back eats are safe.
                    if (eat_valid && eat_live) begin
                        map[eat_loc[AW-1:0]] <= 2'd0;
                        eat_kind             <= eat_tile;
                        score_out            <= score_add(score_out, eat_pts);
                        if (eat_tile == 2'd2) timer <= TW'(POWER_TICKS);
                        if (pellets_left == CW'(1)) begin
                            level_out    <= level_out + 8'd1;
                            timer        <= '0;
                            state        <= S_REFILL;
                            busy         <= 1'b1;
                            pellets_left <= '0;
                            sweep_idx    <= '0;
                            sweep_row    <= '0;
                            sweep_col    <= '0;
                        end else begin
                            pellets_left <= pellets_left - CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Reads the map before any same-cycle eat write lands, so pixels see the old tile.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_dot   <= 1'b0;
            is_power <= 1'b0;
            is_wall  <= 1'b0;
        end else begin
            is_dot   <= (state == S_RUN) && (pix_tile == 2'd1) && in_square(pix_ox, pix_oy, DOT_PX);
            is_power <= (state == S_RUN) && (pix_tile == 2'd2) && in_square(pix_ox, pix_oy, POWER_PX);
            is_wall  <= (state == S_RUN) && (pix_tile == 2'd3);
        end
    end

endmodule

// File: tb/tb_pellet_map.sv
// Bench for pellet_map: maze-level model checked every cycle plus directed literal expectations.
// A second instance with a 4-bit score exercises saturation under the same stimulus.
module tb_pellet_map;
    localparam int COLS = 20;
    localparam int ROWS = 11;
    localparam int N    = COLS * ROWS;
`ifdef PELLET_BCD_SCORE_EN
    localparam int SMALL_MAX = 9;
`else
    localparam int SMALL_MAX = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic       frame_tick = 1'b0;
    logic       eat_valid = 1'b0;
    logic [9:0] eat_x = '0;
    logic [9:0] eat_y = '0;
    logic       auto_draw = 1'b0;

    logic        eat_done, is_dot, is_power, is_wall, power_active, busy;
    logic [1:0]  eat_kind;
    logic [7:0]  pellets_left, level_out;
    logic [15:0] score_out;
    logic        s_eat_done, s_is_dot, s_is_power, s_is_wall, s_power_active, s_busy;
    logic [1:0]  s_eat_kind;
    logic [7:0]  s_pellets_left, s_level_out;
    logic [3:0]  s_score_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pellet_map u_dut (
        .Clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .frame_tick(frame_tick),
        .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y), .eat_done(eat_done),
        .eat_kind(eat_kind), .is_dot(is_dot), .is_power(is_power), .is_wall(is_wall),
        .power_active(power_active), .pellets_left(pellets_left), .score_out(score_out),
        .level_out(level_out), .busy(busy)
    );

    pellet_map #(.SCORE_W(4)) u_small (
        .Clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .frame_tick(frame_tick),
        .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y), .eat_done(s_eat_done),
        .eat_kind(s_eat_kind), .is_dot(s_is_dot), .is_power(s_is_power), .is_wall(s_is_wall),
        .power_active(s_power_active), .pellets_left(s_pellets_left), .score_out(s_score_out),
        .level_out(s_level_out), .busy(s_busy)
    );

    // W wall, P power pellet, . dot, space empty
    string layout [ROWS] = '{
        "WWWWWWWWWWWWWWWWWWWW",
        "W..................W",
        "W.P.W...W...W...WP.W",
        "W..................W",
        "W...W...W...W...W..W",
        "W......... ........W",
        "W...W...W...W...W..W",
        "W..................W",
        "W.P.W...W...W...WP.W",
        "W..................W",
        "WWWWWWWWWWWWWWWWWWWW"
    };

    int  m_map [ROWS][COLS];
    bit  m_sweep = 1'b1;
    int  m_cnt = 0;
    bit  m_busy = 1'b0;
    int  m_pellets = 0;
    int  m_score = 0;
    int  m_level = 0;
    int  m_timer = 0;
    bit  m_done = 1'b0;
    int  m_kind = 0;
    bit  m_dot = 1'b0;
    bit  m_pow = 1'b0;
    bit  m_wall = 1'b0;

    function automatic int layout_kind(input int r, input int c);
        byte ch;
        ch = layout[r][c];
        if (ch == "W") return 3;
        if (ch == "P") return 2;
        if (ch == ".") return 1;
        return 0;
    endfunction

    function automatic int tile_kind_at(input int x, input int y);
        if (x / 32 >= COLS || y / 32 >= ROWS) return 0;
        return m_map[y / 32][x / 32];
    endfunction

    function automatic bit in_sq(input int ox, input int oy, input int size);
        int lo;
        lo = (32 - size) / 2;
        return ox >= lo && ox < lo + size && oy >= lo && oy < lo + size;
    endfunction

    function automatic logic [31:0] score_view(input int v, input int w);
`ifdef PELLET_BCD_SCORE_EN
        int maxv;
        logic [31:0] r;
        maxv = 1;
        r = '0;
        for (int k = 0; k < w / 4; k++) maxv = maxv * 10;
        maxv = maxv - 1;
        if (v > maxv) v = maxv;
        for (int k = 0; k < w / 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
`else
        int maxv;
        maxv = (1 << w) - 1;
        return (v > maxv) ? maxv : v;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int k;
        if (rst) begin
            m_sweep = 1'b1; m_cnt = 0; m_busy = 1'b0; m_pellets = 0; m_score = 0;
            m_level = 0; m_timer = 0; m_done = 1'b0; m_kind = 0;
            m_dot = 1'b0; m_pow = 1'b0; m_wall = 1'b0;
        end else begin
            k      = tile_kind_at(int'(draw_x), int'(draw_y));
            m_dot  = !m_sweep && k == 1 && in_sq(int'(draw_x) % 32, int'(draw_y) % 32, 5);
            m_pow  = !m_sweep && k == 2 && in_sq(int'(draw_x) % 32, int'(draw_y) % 32, 11);
            m_wall = !m_sweep && k == 3;
            m_done = eat_valid;
            m_kind = 0;
            if (frame_tick && m_timer > 0) m_timer = m_timer - 1;
            if (m_sweep) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == N) begin
                    m_sweep = 1'b0;
                    m_busy = 1'b0;
                    m_pellets = 0;
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) begin
                            m_map[r][c] = layout_kind(r, c);
                            if (m_map[r][c] == 1 || m_map[r][c] == 2) m_pellets = m_pellets + 1;
                        end
                end else begin
                    m_busy = 1'b1;
                end
            end else if (eat_valid) begin
                k = tile_kind_at(int'(eat_x), int'(eat_y));
                if (k == 1 || k == 2) begin
                    m_map[int'(eat_y) / 32][int'(eat_x) / 32] = 0;
                    m_kind = k;
                    m_score = m_score + ((k == 2) ? 5 : 1);
                    if (k == 2) m_timer = 480;
                    m_pellets = m_pellets - 1;
                    if (m_pellets == 0) begin
                        m_level = (m_level + 1) % 256;
                        m_timer = 0;
                        m_sweep = 1'b1;
                        m_cnt = 0;
                        m_busy = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("eat_done", eat_done, m_done);
            chk("eat_kind", eat_kind, m_kind);
            chk("is_dot", is_dot, m_dot);
            chk("is_power", is_power, m_pow);
            chk("is_wall", is_wall, m_wall);
            chk("power_active", power_active, m_timer != 0);
            chk("busy", busy, m_busy);
            chk("level_out", level_out, m_level);
            chk("score_out", score_out, score_view(m_score, 16));
            chk("small_score", s_score_out, score_view(m_score, 4));
            if (!m_sweep) chk("pellets_left", pellets_left, m_pellets);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_draw) begin
            draw_x = 10'((int'(draw_x) + 13) % 700);
            draw_y = 10'((int'(draw_y) + 7) % 380);
        end
    endtask

    task automatic eat(input int x, input int y);
        eat_x = 10'(x);
        eat_y = 10'(y);
        eat_valid = 1'b1;
        step();
        eat_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic pix(input string name, input int x, input int y, input bit d, input bit p, input bit w);
        draw_x = 10'(x);
        draw_y = 10'(y);
        step();
        chk({name, "_dot"}, is_dot, d);
        chk({name, "_pow"}, is_power, p);
        chk({name, "_wall"}, is_wall, w);
    endtask

    task automatic sweep_after_reset(input string name);
        for (int i = 1; i <= N; i++) begin
            step();
            if (i == 1 || i == N - 1) chk({name, "_busy_high"}, busy, 1);
        end
        chk({name, "_busy_low"}, busy, 0);
        chk({name, "_pellets"}, pellets_left, 145);
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_score", score_out, 0);
        chk("rst_pellets", pellets_left, 0);
        chk("rst_done", eat_done, 0);
        rst = 1'b0;
        auto_draw = 1'b1;
        sweep_after_reset("sweep1");

        // pixel geometry: dot covers offsets 13..17, power 10..20
        auto_draw = 1'b0;
        pix("dot_ctr", 47, 47, 1, 0, 0);
        pix("dot_lo", 44, 47, 0, 0, 0);
        pix("dot_hi", 49, 47, 1, 0, 0);
        pix("dot_out", 50, 47, 0, 0, 0);
        pix("pow_lo", 74, 74, 0, 1, 0);
        pix("pow_out", 73, 74, 0, 0, 0);
        pix("wall", 5, 5, 0, 0, 1);
        pix("off_x", 700, 5, 0, 0, 0);
        pix("off_y", 5, 400, 0, 0, 0);

        eat(48, 48);
        chk("eat1_done", eat_done, 1);
        chk("eat1_kind", eat_kind, 1);
        chk("eat1_score", score_out, score_view(1, 16));
        chk("eat1_left", pellets_left, 144);
        eat(48, 48);
        chk("eat2_kind", eat_kind, 0);
        chk("eat2_score", score_out, score_view(1, 16));
        eat(700, 48);
        chk("eat_off_done", eat_done, 1);
        chk("eat_off_kind", eat_kind, 0);
        eat(5, 5);
        chk("eat_wall_kind", eat_kind, 0);

        // eat and draw on the same tile: the draw sees the dot still there
        draw_x = 10'd111;
        draw_y = 10'd47;
        eat(112, 48);
        chk("same_tile_old", is_dot, 1);
        step();
        chk("same_tile_new", is_dot, 0);

        auto_draw = 1'b1;
        eat(80, 80);
        chk("pow1_kind", eat_kind, 2);
        chk("pow1_active", power_active, 1);
        chk("pow1_score", score_out, score_view(7, 16));
        for (int i = 0; i < 299; i++) tick();
        chk("pow_mid", power_active, 1);
        frame_tick = 1'b1;
        eat(560, 80);
        frame_tick = 1'b0;
        chk("pow2_kind", eat_kind, 2);
        chk("pow2_score", score_out, score_view(12, 16));
        chk("small_at_12", s_score_out, (SMALL_MAX < 12) ? SMALL_MAX : 12);
        for (int i = 0; i < 479; i++) tick();
        chk("pow_479", power_active, 1);
        tick();
        chk("pow_480", power_active, 0);
        chk("left_141", pellets_left, 141);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                eat_x = 10'(c * 32 + 16);
                eat_y = 10'(r * 32 + 16);
                eat_valid = 1'b1;
                step();
            end
        eat_valid = 1'b0;
        chk("clear_level", level_out, 1);
        chk("clear_busy", busy, 1);
        chk("clear_score", score_out, score_view(161, 16));
        chk("small_sat", s_score_out, SMALL_MAX);

        eat(48, 48);
        chk("refill_eat_done", eat_done, 1);
        chk("refill_eat_kind", eat_kind, 0);
        eat(700, 48);
        chk("refill_off_kind", eat_kind, 0);
        for (int i = 0; i < 300 && busy; i++) step();
        chk("refill_end", busy, 0);
        chk("refill_left", pellets_left, 145);
        chk("refill_level", level_out, 1);
        eat(48, 48);
        chk("restored_kind", eat_kind, 1);
        chk("restored_score", score_out, score_view(162, 16));

        // reset in mid-run, then again mid-sweep together with an eat
        rst = 1'b1;
        #1;
        chk("arst_score", score_out, 0);
        chk("arst_level", level_out, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        eat_x = 10'd48;
        eat_y = 10'd48;
        eat_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midsweep_busy", busy, 0);
        chk("midsweep_done", eat_done, 0);
        step();
        rst = 1'b0;
        eat_valid = 1'b0;
        sweep_after_reset("sweep2");
        chk("sweep2_score", score_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
